norm_sequencer: RTL
===================

// Module: norm_sequencer
//
// PURPOSE
// Sequences post-add/subtract normalization in the FP add/sub datapath. On start it
// selects one of three paths: zero result, carry-out (right shift 1), or leading-zero
// normalization (load LZD, read shift value, left shift). It drives the LZD load, the
// barrel-shifter load/direction/amount and the adjusted exponent, flags overflow and
// underflow, and signals completion with a single-cycle ready pulse.
//
// PARAMETERS
// SWR  26  significand working width of the datapath (26 single, 55 double)
// EWR  5   width of the LZD shift value (5 single, 6 double)
// EW   8   exponent width (8 single, 11 double)
//
// PORTS
// clk            in   1    clock, all state changes on rising edge
// rst            in   1    synchronous reset, active-high
// start_i        in   1    begin normalization; sampled only in IDLE
// zero_i         in   1    add/sub result is all zeros
// carry_i        in   1    add/sub result has carry-out (MSB set)
// exp_i          in   EW   pre-normalization biased exponent
// shift_value_i  in   EWR  leading-zero count from registered LZD
// lzd_load_o     out  1    load strobe to LZD output register
// shft_load_o    out  1    load strobe to barrel-shifter output register
// shft_left_o    out  1    shift direction: 1 = left, 0 = right
// shft_amt_o     out  EWR  shift amount to barrel shifter
// exp_load_o     out  1    load strobe for adjusted exponent register
// exp_o          out  EW   adjusted exponent
// zero_o         out  1    result is zero
// ovf_o          out  1    exponent overflow
// unf_o          out  1    exponent underflow (flush to zero)
// busy_o         out  1    high in every state except IDLE
// ready_o        out  1    one-cycle completion pulse
//
// BEHAVIOUR
// - Reset: state IDLE; every output 0, including exp_o, shft_amt_o and flags.
// - Reset at any point, mid-operation included, aborts: IDLE next cycle, no ready_o.
// - States: IDLE, LZD, CALC, SHIFT, DONE.
// - IDLE & start_i: register exp_i/zero_i/carry_i; clear zero_o/ovf_o/unf_o.
//   Priority zero_i > carry_i > normal.
//   zero_i  -> SHIFT; amt 0, exp 0, zero_o=1.
//   carry_i -> SHIFT; shft_left_o=0, amt 1, exp = exp_i+1.
//   normal  -> LZD.
// - LZD: lzd_load_o=1 for exactly this cycle -> CALC.
// - CALC: sample shift_value_i (valid now, one cycle after the load), zero-extended
//   to EW. If shift_value_i >= exp_i: unf_o=1, exp=0. Else exp = exp_i - shift_value_i.
//   shft_left_o=1, shft_amt_o=shift_value_i -> SHIFT.
// - SHIFT: shft_load_o=1 and exp_load_o=1 for one cycle -> DONE.
// - DONE: ready_o=1 for one cycle -> IDLE.
// - Carry overflow: if exp_i >= 2^EW-2, ovf_o=1 and exp_o = all ones; no wrap-around.
// - Latency from the start_i sample edge to ready_o:
//   normal path 4 cycles (LZD, CALC, SHIFT, DONE); carry and zero paths 2 cycles.
// - start_i while busy_o=1 is ignored. start_i in DONE is ignored.
//   Back-to-back: a new start is accepted in the IDLE cycle after DONE.
// - exp_o, shft_amt_o, shft_left_o and flags are registered and hold until the next
//   accepted start. Strobes (lzd/shft/exp load, ready_o) are high only in their state.
//
// TESTING
// 1 Normal: exp_i=8'd130, shift_value_i=5'd3 -> lzd_load@+1, shft_load/exp_load@+3,
//   shft_left=1, amt=3, exp_o=127, ready_o@+4, no flags.
// 2 Carry: carry_i=1, exp_i=8'd100 -> shft_left=0, amt=1, exp_o=101, ready_o@+2,
//   lzd_load_o never high.
// 3 Overflow: carry_i=1, exp_i=8'd254 -> ovf_o=1, exp_o=8'hFF.
//   Underflow: exp_i=8'd2, shift_value_i=5'd4 -> unf_o=1, exp_o=0.
// 4 Zero priority: zero_i=1, carry_i=1 -> zero_o=1, exp_o=0, amt=0, ready_o@+2.
// 5 Robustness: start_i pulsed in LZD/CALC is ignored (single ready_o). rst in CALC
//   -> IDLE and all outputs 0 next cycle, no ready_o. Back-to-back start accepted
//   in the IDLE cycle after DONE.

Source files
------------

// File: rtl/norm_sequencer.sv
// rtl/norm_sequencer.sv - FP add/sub post-normalization sequencer
//
// Sequences normalization of an add/sub result along one of three paths:
// zero result, carry-out (right shift by one) or leading-zero normalization
// (load LZD, read the shift value, left shift). All outputs are registered.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start_i         begin normalization (sampled only in IDLE)
//   zero_i          add/sub result is zero
//   carry_i         add/sub result has a carry-out
//   exp_i           pre-normalization biased exponent
//   shift_value_i   leading-zero count from the registered LZD
//   lzd_load_o      LZD output register load strobe
//   shft_load_o     barrel-shifter output register load strobe
//   shft_left_o     shift direction, 1 = left
//   shft_amt_o      shift amount
//   exp_load_o      adjusted exponent register load strobe
//   exp_o           adjusted exponent
//   zero_o, ovf_o, unf_o   result flags
//   busy_o          high in every state except IDLE
//   ready_o         one-cycle completion pulse

module norm_sequencer #(
    parameter int SWR = 26,
    parameter int EWR = 5,
    parameter int EW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           zero_i,
    input  logic           carry_i,
    input  logic [EW-1:0]  exp_i,
    input  logic [EWR-1:0] shift_value_i,
    output logic           lzd_load_o,
    output logic           shft_load_o,
    output logic           shft_left_o,
    output logic [EWR-1:0] shft_amt_o,
    output logic           exp_load_o,
    output logic [EW-1:0]  exp_o,
    output logic           zero_o,
    output logic           ovf_o,
    output logic           unf_o,
    output logic           busy_o,
    output logic           ready_o
);

    // The leading-zero count must fit in the exponent and cover the significand.
    if (EW < EWR || SWR < 2) begin : g_param_check
        $error("norm_sequencer: inconsistent SWR/EWR/EW");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LZD,
        S_CALC,
        S_SHIFT,
        S_DONE
    } state_t;

    // A carry from 2^EW-2 upward would reach the reserved all-ones exponent.
    localparam logic [EW-1:0]  OVF_TH  = {{(EW-1){1'b1}}, 1'b0};
    localparam logic [EW-1:0]  EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EWR-1:0] AMT_ONE = {{(EWR-1){1'b0}}, 1'b1};

    state_t        state;
    logic [EW-1:0] exp_r;
    logic [EW-1:0] shift_ext;

    assign shift_ext = {{(EW-EWR){1'b0}}, shift_value_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            exp_r       <= '0;
            lzd_load_o  <= 1'b0;
            shft_load_o <= 1'b0;
            shft_left_o <= 1'b0;
            shft_amt_o  <= '0;
            exp_load_o  <= 1'b0;
            exp_o       <= '0;
            zero_o      <= 1'b0;
            ovf_o       <= 1'b0;
            unf_o       <= 1'b0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
        end else begin
            // Strobes are asserted on entry to their state and drop after one cycle.
            lzd_load_o  <= 1'b0;
            shft_load_o <= 1'b0;
            exp_load_o  <= 1'b0;
            ready_o     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        exp_r  <= exp_i;
                        zero_o <= 1'b0;
                        ovf_o  <= 1'b0;
                        unf_o  <= 1'b0;
                        busy_o <= 1'b1;
                        if (zero_i) begin
                            state       <= S_SHIFT;
                            shft_load_o <= 1'b1;
                            exp_load_o  <= 1'b1;
                            shft_left_o <= 1'b0;
                            shft_amt_o  <= '0;
                            exp_o       <= '0;
                            zero_o      <= 1'b1;
                        end else if (carry_i) begin
                            state       <= S_SHIFT;
                            shft_load_o <= 1'b1;
                            exp_load_o  <= 1'b1;
                            shft_left_o <= 1'b0;
                            shft_amt_o  <= AMT_ONE;
                            if (exp_i >= OVF_TH) begin
                                ovf_o <= 1'b1;
                                exp_o <= '1;
                            end else begin
                                exp_o <= exp_i + EXP_ONE;
                            end
                        end else begin
                            state      <= S_LZD;
                            lzd_load_o <= 1'b1;
                        end
                    end
                end
                S_LZD: begin
                    state <= S_CALC;
                end
                S_CALC: begin
                    // The LZD register was loaded on the previous edge, so its
                    // count is valid in this cycle.
                    state       <= S_SHIFT;
                    shft_load_o <= 1'b1;
                    exp_load_o  <= 1'b1;
                    shft_left_o <= 1'b1;
                    shft_amt_o  <= shift_value_i;
                    if (shift_ext >= exp_r) begin
                        unf_o <= 1'b1;
                        exp_o <= '0;
                    end else begin
                        exp_o <= exp_r - shift_ext;
                    end
                end
                S_SHIFT: begin
                    state   <= S_DONE;
                    ready_o <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
